// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: next-PC op encodings, reset PC
// and the NOP instruction word.
package mips_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BEQ = 3'd1,
        NPC_BNE = 3'd2,
        NPC_J   = 3'd3,
        NPC_JR  = 3'd4
    } npc_op_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage, driven by the
// branch/jump resolved in decode.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic [2:0]  d_npc_op,
    input  logic        d_equal,
    input  logic [31:0] d_rs_data,
    input  logic        d_valid,
    input  logic        stall,
    output logic [31:0] npc,
    output logic        d_redirect
);

    logic [31:0] seq_pc;
    logic [31:0] d_pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [2:0]  op_eff;
    logic        unused_instr_bits;

    // Opcode bits are decoded upstream; only the immediate fields matter here.
    assign unused_instr_bits = &{1'b0, d_instr[31:26]};

    always_comb begin
        seq_pc    = f_pc + 32'd4;
        d_pc4     = d_pc + 32'd4;
        br_target = d_pc4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
        j_target  = {d_pc4[31:28], d_instr[25:0], 2'b00};
        // A bubble in decode must never steer fetch.
        op_eff    = d_valid ? d_npc_op : NPC_SEQ;

        npc        = seq_pc;
        d_redirect = 1'b0;

        if (!stall) begin
            case (op_eff)
                NPC_BEQ: if (d_equal) begin
                    npc        = br_target;
                    d_redirect = 1'b1;
                end
                NPC_BNE: if (!d_equal) begin
                    npc        = br_target;
                    d_redirect = 1'b1;
                end
                NPC_J: begin
                    npc        = j_target;
                    d_redirect = 1'b1;
                end
                NPC_JR: begin
                    npc        = d_rs_data;
                    d_redirect = 1'b1;
                end
                default: begin
                    npc        = seq_pc;
                    d_redirect = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/f_pc_fd_reg.sv
// Fetch PC and F/D pipeline register with single-delay-slot redirects;
// the delay-slot instruction always flows into decode untouched.
module f_pc_fd_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] f_instr,
    input  logic [2:0]  d_npc_op,
    input  logic        d_equal,
    input  logic [31:0] d_rs_data,
    output logic [31:0] f_pc,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic [31:0] d_pc8,
    output logic        d_redirect
);

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] npc;

    npc_calc u_npc_calc (
        .f_pc       (f_pc_q),
        .d_pc       (d_pc_q),
        .d_instr    (d_instr_q),
        .d_npc_op   (d_npc_op),
        .d_equal    (d_equal),
        .d_rs_data  (d_rs_data),
        .d_valid    (d_valid_q),
        .stall      (stall),
        .npc        (npc),
        .d_redirect (d_redirect)
    );

    always_comb begin
        f_pc_d    = f_pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        if (!stall) begin
            f_pc_d    = npc;
            d_pc_d    = f_pc_q;
            d_instr_d = f_instr;
            d_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_q    <= RESET_PC;
            d_pc_q    <= 32'h0;
            d_instr_q <= NOP;
            d_valid_q <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign f_pc    = f_pc_q;
    assign d_pc    = d_pc_q;
    assign d_instr = d_instr_q;
    assign d_valid = d_valid_q;
    assign d_pc8   = d_pc_q + 32'd8;

endmodule

// File: tb/tb_f_pc_fd_reg.sv
// Bench for f_pc_fd_reg: a hand-computed vector table drives one cycle per
// entry; post-edge expectations go through a scoreboard queue.
module tb_f_pc_fd_reg;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] f_instr;
    logic [2:0]  d_npc_op;
    logic        d_equal;
    logic [31:0] d_rs_data;
    logic [31:0] f_pc, d_pc, d_instr, d_pc8;
    logic        d_valid, d_redirect;

    f_pc_fd_reg #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .f_instr    (f_instr),
        .d_npc_op   (d_npc_op),
        .d_equal    (d_equal),
        .d_rs_data  (d_rs_data),
        .f_pc       (f_pc),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_valid    (d_valid),
        .d_pc8      (d_pc8),
        .d_redirect (d_redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] instr;
        logic [2:0]  op;
        logic        eq;
        logic [31:0] rs;
        logic        exp_redir;
        logic [31:0] exp_pc8;
        logic [31:0] exp_fpc;
        logic [31:0] exp_dpc;
        logic [31:0] exp_dinstr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] fpc;
        logic [31:0] dpc;
        logic [31:0] dinstr;
    } post_t;

    localparam int NV = 22;
    vec_t  vecs [NV];
    post_t sb_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    localparam logic [31:0] A0   = 32'h2401_0001, A1 = 32'h2402_0002, A2 = 32'h2404_0004;
    localparam logic [31:0] A3   = 32'h2407_0007, A4 = 32'h2408_0008, A5 = 32'h2409_0009;
    localparam logic [31:0] A6   = 32'h240A_000A, A7 = 32'h240B_000B, A8 = 32'h240C_000C;
    localparam logic [31:0] A9   = 32'h240D_000D;
    localparam logic [31:0] BEQ1 = 32'h1022_FFFE, BEQ2 = 32'h1022_0008;
    localparam logic [31:0] BNE1 = 32'h1422_0010, BNE2 = 32'h1422_0004;
    localparam logic [31:0] JAL1 = 32'h0C00_0C10, JR1  = 32'h03E0_0008;
    localparam logic [31:0] DS1  = 32'h2403_0003, DS2  = 32'h2405_0005;
    localparam logic [31:0] DS3  = 32'h2406_0006, DS4  = 32'h240E_000E;
    localparam logic [31:0] X1   = 32'hDEAD_0001;

    function automatic vec_t mk(logic s, logic [31:0] ins, logic [2:0] op, logic eq,
                                logic [31:0] rs, logic rd, logic [31:0] p8,
                                logic [31:0] fpc, logic [31:0] dpc, logic [31:0] di);
        vec_t v;
        v.stall = s; v.instr = ins; v.op = op; v.eq = eq; v.rs = rs;
        v.exp_redir = rd; v.exp_pc8 = p8;
        v.exp_fpc = fpc; v.exp_dpc = dpc; v.exp_dinstr = di;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, ".f_pc"},     f_pc, 32'h0000_3000);
        chk({tag, ".d_pc"},     d_pc, 32'h0);
        chk({tag, ".d_instr"},  d_instr, 32'h0);
        chk({tag, ".d_valid"},  {31'b0, d_valid}, 32'h0);
        chk({tag, ".d_pc8"},    d_pc8, 32'h8);
        chk({tag, ".redirect"}, {31'b0, d_redirect}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        post_t p;
        // Table: {stall, f_instr, op, eq, rs, redirect, pc8 | post f_pc, d_pc, d_instr}
        vecs[0]  = mk(0, A0,   NPC_J,   0, 0, 0, 32'h8,    32'h3004, 32'h3000, A0);
        vecs[1]  = mk(0, A1,   NPC_SEQ, 0, 0, 0, 32'h3008, 32'h3008, 32'h3004, A1);
        vecs[2]  = mk(0, BEQ1, NPC_SEQ, 0, 0, 0, 32'h300C, 32'h300C, 32'h3008, BEQ1);
        vecs[3]  = mk(0, DS1,  NPC_BEQ, 1, 0, 1, 32'h3010, 32'h3004, 32'h300C, DS1);
        vecs[4]  = mk(0, BNE1, NPC_SEQ, 0, 0, 0, 32'h3014, 32'h3008, 32'h3004, BNE1);
        vecs[5]  = mk(0, A2,   NPC_BNE, 1, 0, 0, 32'h300C, 32'h300C, 32'h3008, A2);
        vecs[6]  = mk(0, A3,   NPC_SEQ, 0, 0, 0, 32'h3010, 32'h3010, 32'h300C, A3);
        vecs[7]  = mk(0, JAL1, NPC_SEQ, 0, 0, 0, 32'h3014, 32'h3014, 32'h3010, JAL1);
        vecs[8]  = mk(0, DS2,  NPC_J,   0, 0, 1, 32'h3018, 32'h3040, 32'h3014, DS2);
        vecs[9]  = mk(0, BNE2, NPC_SEQ, 0, 0, 0, 32'h301C, 32'h3044, 32'h3040, BNE2);
        vecs[10] = mk(0, A4,   NPC_BNE, 0, 0, 1, 32'h3048, 32'h3054, 32'h3044, A4);
        vecs[11] = mk(0, JR1,  NPC_SEQ, 0, 0, 0, 32'h304C, 32'h3058, 32'h3054, JR1);
        vecs[12] = mk(1, X1,   NPC_JR,  0, 32'h1111_0000, 0, 32'h305C, 32'h3058, 32'h3054, JR1);
        vecs[13] = mk(1, X1,   NPC_JR,  0, 32'h1111_0000, 0, 32'h305C, 32'h3058, 32'h3054, JR1);
        vecs[14] = mk(0, DS3,  NPC_JR,  0, 32'h0000_3100, 1, 32'h305C, 32'h3100, 32'h3058, DS3);
        vecs[15] = mk(0, BEQ2, NPC_SEQ, 0, 0, 0, 32'h3060, 32'h3104, 32'h3100, BEQ2);
        vecs[16] = mk(0, A5,   NPC_BEQ, 0, 0, 0, 32'h3108, 32'h3108, 32'h3104, A5);
        vecs[17] = mk(0, A6,   3'd6,    1, 32'h0000_5000, 0, 32'h310C, 32'h310C, 32'h3108, A6);
        vecs[18] = mk(0, JR1,  NPC_SEQ, 0, 0, 0, 32'h3110, 32'h3110, 32'h310C, JR1);
        vecs[19] = mk(0, DS4,  NPC_JR,  0, 32'hFFFF_FFFC, 1, 32'h3114, 32'hFFFF_FFFC, 32'h3110, DS4);
        vecs[20] = mk(0, A7,   NPC_SEQ, 0, 0, 0, 32'h3118, 32'h0000_0000, 32'hFFFF_FFFC, A7);
        vecs[21] = mk(0, A8,   NPC_SEQ, 0, 0, 0, 32'h0000_0004, 32'h0000_0004, 32'h0000_0000, A8);

        reset = 1'b0; stall = 1'b0; f_instr = A0; d_npc_op = NPC_J;
        d_equal = 1'b0; d_rs_data = 32'h0;
        repeat (2) @(negedge clk);
        #1 chk_reset_state("reset");

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall; f_instr = vecs[i].instr; d_npc_op = vecs[i].op;
            d_equal = vecs[i].eq;  d_rs_data = vecs[i].rs;
            sb_q.push_back('{i, vecs[i].exp_fpc, vecs[i].exp_dpc, vecs[i].exp_dinstr});
            #1;
            chk($sformatf("v%0d.redirect", i), {31'b0, d_redirect}, {31'b0, vecs[i].exp_redir});
            chk($sformatf("v%0d.d_pc8", i), d_pc8, vecs[i].exp_pc8);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL v%0d.scoreboard: got empty queue expected entry", i);
            end else begin
                p = sb_q.pop_front();
                chk($sformatf("v%0d.f_pc", p.idx), f_pc, p.fpc);
                chk($sformatf("v%0d.d_pc", p.idx), d_pc, p.dpc);
                chk($sformatf("v%0d.d_instr", p.idx), d_instr, p.dinstr);
                chk($sformatf("v%0d.d_valid", p.idx), {31'b0, d_valid}, 32'h1);
            end
        end

        // Asynchronous reset in mid-cycle while stalled on a pending JR.
        @(negedge clk);
        stall = 1'b1; d_npc_op = NPC_JR; d_rs_data = 32'h0000_7000; f_instr = A9;
        #2 reset = 1'b0;
        #1 chk_reset_state("async_rst");
        @(posedge clk);
        #1 chk_reset_state("rst_hold");

        @(negedge clk);
        reset = 1'b1; stall = 1'b0; d_npc_op = NPC_SEQ;
        @(posedge clk);
        #1;
        chk("post_rst.d_pc", d_pc, 32'h0000_3000);
        chk("post_rst.f_pc", f_pc, 32'h0000_3004);
        chk("post_rst.d_instr", d_instr, A9);
        chk("post_rst.d_valid", {31'b0, d_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
